// File: rtl/vga_sync_gen_pkg.sv
// vga_sync_gen_pkg: 640x480@60Hz timing defaults and the coordinate type shared by the VGA path.
package vga_sync_gen_pkg;
   localparam int CLK_DIV_DEF   = 4;
   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;
   localparam int CW            = 10;
   typedef logic [CW-1:0] coord_t;
   function automatic logic in_span(coord_t v, int lo, int hi);
      return v >= coord_t'(lo) && v <= coord_t'(hi);
   endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing outputs of the sync generator as seen by the pixel generator.
interface vga_sync_gen_if;
   import vga_sync_gen_pkg::*;
   logic   p_tick;
   coord_t x;
   coord_t y;
   logic   video_on;
   logic   hsync;
   logic   vsync;
   logic   frame_tick;
   modport master (output p_tick, x, y, video_on, hsync, vsync, frame_tick);
   modport slave  (input  p_tick, x, y, video_on, hsync, vsync, frame_tick);
endinterface

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// pixel_tick_gen: mod-CLK_DIV counter; tick_o is high on the last count of each period.
module pixel_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
   logic [DW-1:0] div_q, div_d;
   always_comb div_d = (div_q == LAST) ? '0 : div_q + DW'(1);
   always_ff @(posedge clk_i) div_q <= rst_i ? '0 : div_d;
   assign tick_o = div_q == LAST;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-rate h/v counters with registered sync/blank decode and a per-frame strobe.
module vga_sync_gen
   import vga_sync_gen_pkg::*;
#(
   parameter int CLK_DIV   = CLK_DIV_DEF,
   parameter int H_DISPLAY = H_DISPLAY_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_DISPLAY = V_DISPLAY_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF
) (
   input  logic           clk_100MHz,
   input  logic           reset,
   vga_sync_gen_if.master vga
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_LO   = H_DISPLAY + H_FRONT;
   localparam int HS_HI   = HS_LO + H_SYNC - 1;
   localparam int VS_LO   = V_DISPLAY + V_FRONT;
   localparam int VS_HI   = VS_LO + V_SYNC - 1;
   localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
   logic   p_tick, x_end, y_end;
   coord_t x_q, x_d, y_q, y_d;
   logic   hsync_q, hsync_d, vsync_q, vsync_d, vo_q, vo_d;
   pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk_i (clk_100MHz),
      .rst_i (reset),
      .tick_o(p_tick)
   );
   // Decoding from the next-state coordinates keeps the sync/blank flags aligned with x and y.
   always_comb begin
      x_end   = x_q == H_LAST;
      y_end   = y_q == V_LAST;
      x_d     = !p_tick ? x_q : x_end ? '0 : x_q + coord_t'(1);
      y_d     = !(p_tick && x_end) ? y_q : y_end ? '0 : y_q + coord_t'(1);
      hsync_d = !in_span(x_d, HS_LO, HS_HI);
      vsync_d = !in_span(y_d, VS_LO, VS_HI);
      vo_d    = x_d < coord_t'(H_DISPLAY) && y_d < coord_t'(V_DISPLAY);
   end
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         x_q     <= '0;
         y_q     <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         vo_q    <= 1'b1;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         vo_q    <= vo_d;
      end
   end
   assign vga.p_tick     = p_tick;
   assign vga.x          = x_q;
   assign vga.y          = y_q;
   assign vga.video_on   = vo_q;
   assign vga.hsync      = hsync_q;
   assign vga.vsync      = vsync_q;
   assign vga.frame_tick = p_tick & x_end & y_end;
endmodule
